line_option_scheduler: RTL and testbench
========================================

Name: line_option_scheduler

Overview:
- Upstream feeder for the FIFO-driven line solver.
- Holds the candidate option list for every row and column of a SIZE x SIZE nonogram and keeps a circular work queue of unresolved lines.
- Dispatches one (line, option) pair at a time to the solver, then applies its verdict: keep the option, delete it, or mark the line solved.
- Requeues unresolved lines and reports done or stuck.

Parameters:
- SIZE, 3, grid dimension; line ids 0..2*SIZE-1 (rows 0..SIZE-1, columns SIZE..2*SIZE-1).
- MAX_OPTS, 8, max options stored per line; must be <= 2^(SIZE+1)-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load_valid  in  1  option-load beat valid
- load_ready  out  1  high only in LOAD state
- load_row  in  1  1 = row, 0 = column
- load_line  in  SIZE  line index (0..SIZE-1)
- load_option  in  SIZE  candidate bit pattern
- load_done  in  1  pulse: loading finished, start solving
- option  out  SIZE  option under test
- line_ind  out  SIZE  line index to solver
- row  out  1  row/column flag to solver
- option_num  out  SIZE+1  current option count of that line
- valid_op  out  1  one-cycle dispatch strobe
- res_valid  in  1  one-cycle solver verdict strobe
- res_put_back  in  1  1 = option consistent, keep it
- done  out  1  level: queue empty, all lines solved
- stuck  out  1  level: full queue pass with no change
- error  out  1  level, sticky: option overflow or zero-option line

Behaviour:
- Reset: load_ready=0, valid_op=0, done=0, stuck=0, error=0, option/line_ind/row/option_num=0. All counts, cursors and queue pointers are 0. Next state is LOAD. Reset mid-operation aborts immediately with the same values.
- LOAD:
  - load_ready=1.
  - Each accepted beat appends load_option to line id = load_row ? load_line : SIZE+load_line; count increments.
  - A beat to a line already at MAX_OPTS is dropped and sets error.
  - On load_done, go to INIT.
- INIT:
  - One cycle per line id, ascending.
  - count>0: push id to queue. count==0: set error, do not push.
  - Then go to DISPATCH.
- DISPATCH:
  - Queue empty: go to DONE.
  - Else if since_change == occupancy and occupancy>0: go to STUCK.
  - Else peek head id, register option=opts[id][cursor[id]], line_ind, row, option_num=count[id], pulse valid_op for exactly one cycle, go to WAIT.
- WAIT:
  - Hold outputs stable; valid_op=0. Wait indefinitely for res_valid.
  - res_put_back=1: cursor++.
  - res_put_back=0 and count>1: delete option by copying opts[count-1] into slot cursor, count--, cursor unchanged; since_change=0.
  - res_put_back=0 and count==1: line solved; pop, no requeue; since_change=0.
  - res_valid arriving in the same cycle as valid_op is legal (zero-latency solver).
- ADVANCE (1 cycle after a verdict, unless the line was solved):
  - cursor < count: keep line at head, go to DISPATCH.
  - cursor >= count: cursor=0, pop head, push same id to tail, since_change++, go to DISPATCH.
  - Push and pop in the same cycle leave occupancy unchanged.
- Queue: depth 2*SIZE circular buffer. Each id is present at most once, so it never overflows; wrap via modulo pointers.
- DONE / STUCK: terminal, outputs held until rst. done and stuck are mutually exclusive.
- Width rules: count is SIZE+1 bits; cursor is clog2(MAX_OPTS+1) bits. Deleting when count==1 never underflows because it takes the solved path.

Decomposition:
- Shared package nonogram_pkg: SIZE default, NUM_LINES=2*SIZE, line_id_t, state enum {LOAD, INIT, DISPATCH, WAIT, ADVANCE, DONE, STUCK}, line_id-to-(row, index) mapping function.
- Sub-module: line_id_queue (circular FIFO of line ids with push/pop/peek/occupancy, simultaneous push+pop supported).

Test Plan:
- SIZE=3, load one option per line (6 beats), load_done; solver answers put_back=0 each time -> six valid_op strobes in order ids 0..5, option_num=1 each, then done=1.
- Row 0 loaded with options 3'b110, 3'b011; first verdict put_back=0 -> count 2->1, slot 0 now 3'b011; next dispatch shows option 3'b011, option_num=1.
- Every line has 2 options; solver always put_back=1 -> each line requeued once, then stuck=1 after 6 requeues without change; done stays 0.
- Load 9 options to column 1 -> 9th beat dropped, error=1, count=8.
- Column 2 loaded with no options -> error=1 after INIT; remaining 5 lines still dispatch.
- Assert rst while in WAIT -> next cycle valid_op=0, load_ready=1, done=0, stuck=0, error=0; reload and rerun completes normally.

Source files
------------

// File: rtl/nonogram_pkg.sv
// Shared types and helpers for the nonogram line-option scheduler.
package nonogram_pkg;

    localparam int SIZE      = 3;
    localparam int NUM_LINES = 2 * SIZE;

    typedef logic [$clog2(NUM_LINES)-1:0] line_id_t;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_INIT,
        ST_DISPATCH,
        ST_WAIT,
        ST_ADVANCE,
        ST_DONE,
        ST_STUCK
    } sched_state_t;

    // Line ids 0..size-1 are rows, size..2*size-1 are columns.
    function automatic bit line_is_row(int id, int size);
        return id < size;
    endfunction

    function automatic int line_index(int id, int size);
        return (id < size) ? id : id - size;
    endfunction

endpackage

// File: rtl/line_id_queue.sv
// Circular FIFO of line ids; push and pop may happen in the same cycle.
module line_id_queue #(
    parameter int DEPTH = 6,
    parameter int W     = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_id,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [OCC_W-1:0] occupancy
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; a push+pop pair leaves occupancy alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/line_option_scheduler.sv
// Holds per-line option lists, cycles unresolved lines through a work queue,
// and hands one (line, option) pair at a time to the line solver.
module line_option_scheduler #(
    parameter int SIZE     = nonogram_pkg::SIZE,
    parameter int MAX_OPTS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic            load_row,
    input  logic [SIZE-1:0] load_line,
    input  logic [SIZE-1:0] load_option,
    input  logic            load_done,
    output logic [SIZE-1:0] option,
    output logic [SIZE-1:0] line_ind,
    output logic            row,
    output logic [SIZE:0]   option_num,
    output logic            valid_op,
    input  logic            res_valid,
    input  logic            res_put_back,
    output logic            done,
    output logic            stuck,
    output logic            error
);
    import nonogram_pkg::*;

    localparam int NUM_LINES = 2 * SIZE;
    localparam int LW        = $clog2(NUM_LINES);
    localparam int CNT_W     = SIZE + 1;
    localparam int CUR_W     = $clog2(MAX_OPTS + 1);
    localparam int OW        = (MAX_OPTS > 1) ? $clog2(MAX_OPTS) : 1;
    localparam int OCC_W     = $clog2(NUM_LINES + 1);

    sched_state_t      state;
    logic [SIZE-1:0]   opts   [NUM_LINES][MAX_OPTS];
    logic [CNT_W-1:0]  count  [NUM_LINES];
    logic [CUR_W-1:0]  cursor [NUM_LINES];
    logic [LW-1:0]     init_id;
    logic [OCC_W-1:0]  since_change;

    logic              q_push, q_pop;
    logic [LW-1:0]     q_push_id, head;
    logic [OCC_W-1:0]  occ;

    logic [LW-1:0]     load_id;
    logic [CNT_W-1:0]  cur_h, cnt_h;
    logic [OW-1:0]     cur_idx, last_idx, load_slot;
    logic              need_requeue;

    assign load_ready   = (state == ST_LOAD) && !rst;
    assign load_id      = load_row ? LW'(load_line) : LW'(int'(load_line) + SIZE);
    assign load_slot    = OW'(count[load_id]);
    assign cur_h        = CNT_W'(cursor[head]);
    assign cnt_h        = count[head];
    assign cur_idx      = OW'(cursor[head]);
    assign last_idx     = OW'(cnt_h - 1'b1);
    assign need_requeue = cur_h >= cnt_h;

    line_id_queue #(.DEPTH(NUM_LINES), .W(LW)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_id   (q_push_id),
        .pop       (q_pop),
        .head      (head),
        .occupancy (occ)
    );

    // Queue controls: seed during INIT, drop solved lines, rotate exhausted lines.
    always_comb begin
        q_push    = 1'b0;
        q_pop     = 1'b0;
        q_push_id = head;
        case (state)
            ST_INIT: begin
                q_push    = (count[init_id] != '0);
                q_push_id = init_id;
            end
            ST_WAIT:    q_pop = res_valid && !res_put_back && (cnt_h == CNT_W'(1));
            ST_ADVANCE: begin
                q_pop  = need_requeue;
                q_push = need_requeue;
            end
            default: ;
        endcase
    end

    // Scheduler FSM with registered solver-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_LOAD;
            valid_op     <= 1'b0;
            done         <= 1'b0;
            stuck        <= 1'b0;
            error        <= 1'b0;
            option       <= '0;
            line_ind     <= '0;
            row          <= 1'b0;
            option_num   <= '0;
            init_id      <= '0;
            since_change <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                count[i]  <= '0;
                cursor[i] <= '0;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_valid) begin
                        if (count[load_id] == CNT_W'(MAX_OPTS)) begin
                            error <= 1'b1;
                        end else begin
                            opts[load_id][load_slot] <= load_option;
                            count[load_id]           <= count[load_id] + 1'b1;
                        end
                    end
                    if (load_done) state <= ST_INIT;
                end
                ST_INIT: begin
                    if (count[init_id] == '0) error <= 1'b1;
                    if (init_id == LW'(NUM_LINES - 1)) state <= ST_DISPATCH;
                    else                                init_id <= init_id + 1'b1;
                end
                ST_DISPATCH: begin
                    if (occ == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (since_change == occ) begin
                        stuck <= 1'b1;
                        state <= ST_STUCK;
                    end else begin
                        option     <= opts[head][cur_idx];
                        line_ind   <= SIZE'(line_index(int'(head), SIZE));
                        row        <= line_is_row(int'(head), SIZE);
                        option_num <= cnt_h;
                        valid_op   <= 1'b1;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    valid_op <= 1'b0;
                    if (res_valid) begin
                        if (res_put_back) begin
                            cursor[head] <= cursor[head] + 1'b1;
                            state        <= ST_ADVANCE;
                        end else if (cnt_h > CNT_W'(1)) begin
                            // Delete by moving the last option into the rejected slot.
                            opts[head][cur_idx] <= opts[head][last_idx];
                            count[head]         <= cnt_h - 1'b1;
                            since_change        <= '0;
                            state               <= ST_ADVANCE;
                        end else begin
                            since_change <= '0;
                            state        <= ST_DISPATCH;
                        end
                    end
                end
                ST_ADVANCE: begin
                    if (need_requeue) begin
                        cursor[head] <= '0;
                        since_change <= since_change + 1'b1;
                    end
                    state <= ST_DISPATCH;
                end
                ST_DONE, ST_STUCK: ;
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_line_option_scheduler.sv
// Bench for line_option_scheduler: scenario table, randomized runs against a
// queue-based model, and hand sequences for deletion and mid-run reset.
module tb_line_option_scheduler;

    localparam int SIZE = 3;
    localparam int NL   = 2 * SIZE;
    localparam int MAXO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_valid, load_ready, load_row, load_done;
    logic [SIZE-1:0] load_line, load_option;
    logic [SIZE-1:0] option, line_ind;
    logic            row, valid_op, res_valid, res_put_back;
    logic [SIZE:0]   option_num;
    logic            done, stuck, error;

    always #5 clk = ~clk;

    line_option_scheduler #(.SIZE(SIZE), .MAX_OPTS(MAXO)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_row(load_row),
        .load_line(load_line), .load_option(load_option), .load_done(load_done),
        .option(option), .line_ind(line_ind), .row(row), .option_num(option_num),
        .valid_op(valid_op), .res_valid(res_valid), .res_put_back(res_put_back),
        .done(done), .stuck(stuck), .error(error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: option lists as queues, work list as a queue of ids.
    int m_opts [NL][$];
    int m_cur  [NL];
    int m_wq   [$];
    int m_since;
    bit m_err;

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) begin
            m_opts[i].delete();
            m_cur[i] = 0;
        end
        m_wq.delete();
        m_since = 0;
        m_err   = 0;
    endfunction

    function automatic void model_init();
        for (int i = 0; i < NL; i++)
            if (m_opts[i].size() > 0) m_wq.push_back(i);
            else                      m_err = 1;
    endfunction

    function automatic bit model_done();
        return m_wq.size() == 0;
    endfunction

    function automatic bit model_stuck();
        return m_wq.size() != 0 && m_since == m_wq.size();
    endfunction

    function automatic void model_verdict(input bit keep);
        int id = m_wq[0];
        if (keep) m_cur[id]++;
        else if (m_opts[id].size() > 1) begin
            m_opts[id][m_cur[id]] = m_opts[id][m_opts[id].size() - 1];
            void'(m_opts[id].pop_back());
            m_since = 0;
        end else begin
            void'(m_wq.pop_front());
            m_since = 0;
            return;
        end
        if (m_cur[id] >= m_opts[id].size()) begin
            m_cur[id] = 0;
            void'(m_wq.pop_front());
            m_wq.push_back(id);
            m_since++;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1; load_valid = 1'b0; load_done = 1'b0; load_row = 1'b0;
        load_line = '0; load_option = '0; res_valid = 1'b0; res_put_back = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic beat(input int id, input int val);
        @(negedge clk);
        load_valid  = 1'b1;
        load_row    = (id < SIZE);
        load_line   = SIZE'((id < SIZE) ? id : id - SIZE);
        load_option = SIZE'(val);
    endtask

    // nopts nibble i = number of options loaded for line id i.
    task automatic load_scenario(input logic [23:0] nopts);
        model_reset();
        for (int id = 0; id < NL; id++) begin
            for (int k = 0; k < int'(nopts[4*id +: 4]); k++) begin
                int v = $urandom_range(0, 7);
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    load_valid = 1'b0;
                end
                beat(id, v);
                if (m_opts[id].size() >= MAXO) m_err = 1;
                else                           m_opts[id].push_back(v);
            end
        end
        @(negedge clk);
        load_valid = 1'b0;
        chk("load_error", error, m_err);
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        model_init();
    endtask

    task automatic run_solver(input int policy, output int ndisp);
        int cyc = 0;
        bit fin = 0;
        ndisp = 0;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            res_valid = 1'b0;
            if (done || stuck) fin = 1;
            else if (valid_op) begin
                int id, d;
                bit pb;
                ndisp++;
                chk("disp_allowed", model_done() || model_stuck(), 0);
                if (model_done() || model_stuck()) begin
                    fin = 1;
                    break;
                end
                id = m_wq[0];
                chk("disp_option", option, m_opts[id][m_cur[id]]);
                chk("disp_line", line_ind, (id < SIZE) ? id : id - SIZE);
                chk("disp_row", row, id < SIZE);
                chk("disp_num", option_num, m_opts[id].size());
                pb = (policy == 0) ? 1'b0 : (policy == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
                d  = $urandom_range(0, 2);
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    cyc++;
                    chk("hold_valid_op", valid_op, 0);
                    chk("hold_line", line_ind, (id < SIZE) ? id : id - SIZE);
                end
                res_valid    = 1'b1;
                res_put_back = pb;
                model_verdict(pb);
            end
        end
        res_valid = 1'b0;
        if (!fin) chk("solver_timeout", 1, 0);
        chk("end_done", done, model_done());
        chk("end_stuck", stuck, model_stuck());
        chk("end_error", error, m_err);
    endtask

    task automatic wait_valid(input string name);
        int c = 0;
        do begin
            @(negedge clk);
            res_valid = 1'b0;
            c++;
        end while (!valid_op && c < 60);
        chk(name, valid_op, 1);
    endtask

    typedef struct packed {
        logic [23:0] nopts;
        logic [1:0]  policy;   // 0 delete, 1 keep, 2 random
        logic        exp_done;
        logic        exp_stuck;
        logic        exp_err;
        logic [7:0]  exp_disp;
    } scen_t;

    scen_t tbl [6];

    initial begin
        int nd;

        tbl[0] = '{24'h111111, 2'd0, 1'b1, 1'b0, 1'b0, 8'd6};
        tbl[1] = '{24'h222222, 2'd1, 1'b0, 1'b1, 1'b0, 8'd12};
        tbl[2] = '{24'h011111, 2'd0, 1'b1, 1'b0, 1'b1, 8'd5};
        tbl[3] = '{24'h191111, 2'd0, 1'b1, 1'b0, 1'b1, 8'd13};
        tbl[4] = '{24'h222222, 2'd0, 1'b1, 1'b0, 1'b0, 8'd12};
        tbl[5] = '{24'h111111, 2'd1, 1'b0, 1'b1, 1'b0, 8'd6};

        // Reset state.
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_valid_op", valid_op, 0);
        chk("rst_done", done, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_error", error, 0);
        chk("rst_option_num", option_num, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_load_ready", load_ready, 1);

        // Scenario table.
        for (int s = 0; s < 6; s++) begin
            do_reset();
            load_scenario(tbl[s].nopts);
            run_solver(int'(tbl[s].policy), nd);
            chk($sformatf("tbl%0d_done", s), done, tbl[s].exp_done);
            chk($sformatf("tbl%0d_stuck", s), stuck, tbl[s].exp_stuck);
            chk($sformatf("tbl%0d_error", s), error, tbl[s].exp_err);
            chk($sformatf("tbl%0d_dispatches", s), nd, tbl[s].exp_disp);
        end

        // Randomized option loads and verdicts.
        for (int r = 0; r < 12; r++) begin
            logic [23:0] np;
            for (int i = 0; i < NL; i++) begin
                int v = $urandom_range(0, 4);
                if ($urandom_range(0, 9) == 0) v = 9;
                np[4*i +: 4] = 4'(v);
            end
            do_reset();
            load_scenario(np);
            run_solver(2, nd);
        end

        // Deleting slot 0 of a two-option row moves the last option into it.
        do_reset();
        beat(0, 3'b110);
        beat(0, 3'b011);
        for (int id = 1; id < NL; id++) beat(id, id);
        @(negedge clk);
        load_valid = 1'b0;
        load_done  = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        wait_valid("del_first_dispatch");
        chk("del_first_option", option, 3'b110);
        chk("del_first_num", option_num, 2);
        res_valid    = 1'b1;
        res_put_back = 1'b0;
        wait_valid("del_second_dispatch");
        chk("del_second_option", option, 3'b011);
        chk("del_second_num", option_num, 1);
        chk("del_second_line", line_ind, 0);
        chk("del_second_row", row, 1);

        // Reset while waiting on the solver, then a clean rerun.
        do_reset();
        load_scenario(24'h011111);
        wait_valid("rstwait_dispatch");
        chk("rstwait_error_before", error, 1);
        chk("rstwait_load_ready_busy", load_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstwait_valid_op", valid_op, 0);
        chk("rstwait_load_ready", load_ready, 1);
        chk("rstwait_done", done, 0);
        chk("rstwait_stuck", stuck, 0);
        chk("rstwait_error", error, 0);
        load_scenario(24'h111111);
        run_solver(0, nd);
        chk("rerun_done", done, 1);
        chk("rerun_dispatches", nd, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
